// File: rtl/pc_gen_unit.sv
// Fetch-stage program counter with sequential/branch/call/return next-PC selection,
// a circular return-address stack and a run/halt state machine.
module pc_gen_unit #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               INC       = 2,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             freeze,
    input  logic                             halt,
    input  logic                             branch_taken,
    input  logic [WIDTH-1:0]                 branch_target,
    input  logic                             call,
    input  logic                             ret,
    output logic [WIDTH-1:0]                 pc_out,
    output logic [WIDTH-1:0]                 pc_seq,
    output logic                             halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_err
);

    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [CW-1:0]    FULL   = CW'(RAS_DEPTH);
    localparam logic [PW-1:0]    PTR_MAX = PW'(RAS_DEPTH - 1);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t            state;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     ptr_inc;
    logic [PW-1:0]     ptr_dec;
    logic [WIDTH-1:0]  ras_mem [RAS_DEPTH];
    logic              active;
    logic              push_en;

    assign pc_seq = pc_out + INC_W;
    assign halted = (state == HALTED);

    // Pointer wraps explicitly so non-power-of-two depths still behave circularly.
    assign ptr_inc = (ptr == PTR_MAX) ? '0 : ptr + PW'(1);
    assign ptr_dec = (ptr == '0) ? PTR_MAX : ptr - PW'(1);

    assign active  = !freeze && (state == RUN) && !halt;
    assign push_en = active && !ret && branch_taken && call;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            pc_out    <= RESET_VEC;
            ptr       <= '0;
            ras_count <= '0;
            ras_err   <= 1'b0;
        end else if (!freeze && state == RUN) begin
            if (halt) begin
                state <= HALTED;
            end else if (ret) begin
                if (ras_count != '0) begin
                    pc_out    <= ras_mem[ptr_dec];
                    ptr       <= ptr_dec;
                    ras_count <= ras_count - CW'(1);
                end else begin
                    pc_out  <= pc_seq;
                    ras_err <= 1'b1;
                end
            end else if (branch_taken) begin
                pc_out <= branch_target;
                if (call) begin
                    ptr <= ptr_inc;
                    // A full stack overwrites its oldest entry, so the count saturates.
                    if (ras_count == FULL) begin
                        ras_err <= 1'b1;
                    end else begin
                        ras_count <= ras_count + CW'(1);
                    end
                end
            end else begin
                pc_out <= pc_seq;
            end
        end
    end

    // Entry contents need no reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            ras_mem[ptr] <= pc_seq;
        end
    end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit (WIDTH=16, RESET_VEC=0, INC=2, RAS_DEPTH=4).
module tb_pc_gen_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        halt;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        call;
    logic        ret;
    logic [15:0] pc_out;
    logic [15:0] pc_seq;
    logic        halted;
    logic [2:0]  ras_count;
    logic        ras_err;

    int errors = 0;
    int checks = 0;

    pc_gen_unit #(
        .WIDTH(16),
        .RESET_VEC(16'h0000),
        .INC(2),
        .RAS_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .halt(halt),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .call(call),
        .ret(ret),
        .pc_out(pc_out),
        .pc_seq(pc_seq),
        .halted(halted),
        .ras_count(ras_count),
        .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic clear_inputs();
        freeze = 0; halt = 0; branch_taken = 0; call = 0; ret = 0; branch_target = 16'h0000;
    endtask

    task automatic jump_to(input logic [15:0] addr);
        clear_inputs();
        branch_taken = 1; branch_target = addr;
        step();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_output("reset_pc", pc_out, 16'h0000);
        check_output("reset_halted", halted, 1'b0);
        check_output("reset_count", ras_count, 3'd0);
        check_output("reset_err", ras_err, 1'b0);
        check_output("reset_seq", pc_seq, 16'h0002);

        step(); check_output("inc_1", pc_out, 16'h0002);
        step(); check_output("inc_2", pc_out, 16'h0004);
        step(); check_output("inc_3", pc_out, 16'h0006);
        check_output("inc_seq", pc_seq, 16'h0008);

        #3;
        rst = 1'b1;
        #1;
        check_output("async_rst_pc", pc_out, 16'h0000);
        rst = 1'b0;

        jump_to(16'h0010);
        check_output("jump_0010", pc_out, 16'h0010);
        freeze = 1; branch_taken = 1; branch_target = 16'h0100; halt = 1; ret = 1;
        step(); step();
        check_output("freeze_pc", pc_out, 16'h0010);
        check_output("freeze_over_halt", halted, 1'b0);
        freeze = 0; halt = 0; ret = 0;
        step();
        check_output("unfreeze_branch", pc_out, 16'h0100);

        jump_to(16'h0020);
        branch_taken = 1; call = 1; branch_target = 16'h0200;
        step();
        check_output("call_pc", pc_out, 16'h0200);
        check_output("call_count", ras_count, 3'd1);
        clear_inputs();
        ret = 1;
        step();
        check_output("ret_pc", pc_out, 16'h0022);
        check_output("ret_count", ras_count, 3'd0);
        check_output("ret_err", ras_err, 1'b0);

        jump_to(16'h0030);
        ret = 1;
        step();
        check_output("underflow_pc", pc_out, 16'h0032);
        check_output("underflow_err", ras_err, 1'b1);
        check_output("underflow_count", ras_count, 3'd0);
        clear_inputs();

        pulse_reset();
        for (int k = 1; k <= 5; k++) begin
            jump_to(16'(k * 16));
            branch_taken = 1; call = 1; branch_target = 16'h0800;
            step();
            clear_inputs();
            if (k == 4) begin
                check_output("full_count", ras_count, 3'd4);
                check_output("full_err", ras_err, 1'b0);
            end
        end
        check_output("overflow_count", ras_count, 3'd4);
        check_output("overflow_err", ras_err, 1'b1);
        ret = 1;
        step(); check_output("pop_1", pc_out, 16'h0052);
        step(); check_output("pop_2", pc_out, 16'h0042);
        step(); check_output("pop_3", pc_out, 16'h0032);
        step(); check_output("pop_4", pc_out, 16'h0022);
        check_output("pop_count", ras_count, 3'd0);
        step(); check_output("pop_empty", pc_out, 16'h0024);
        clear_inputs();

        pulse_reset();
        jump_to(16'h0060);
        branch_taken = 1; call = 1; branch_target = 16'h0300;
        step();
        check_output("prio_call_pc", pc_out, 16'h0300);
        ret = 1; branch_taken = 1; call = 1; branch_target = 16'h0700;
        step();
        check_output("ret_wins_pc", pc_out, 16'h0062);
        check_output("ret_wins_count", ras_count, 3'd0);
        check_output("ret_wins_err", ras_err, 1'b0);
        clear_inputs();
        call = 1;
        step();
        check_output("call_no_branch_pc", pc_out, 16'h0064);
        check_output("call_no_branch_count", ras_count, 3'd0);
        clear_inputs();

        jump_to(16'h0040);
        halt = 1; ret = 1; branch_taken = 1; branch_target = 16'h0900;
        step();
        check_output("halt_pc", pc_out, 16'h0040);
        check_output("halt_flag", halted, 1'b1);
        clear_inputs();
        branch_taken = 1; branch_target = 16'h0500;
        step(); step();
        check_output("halted_hold_pc", pc_out, 16'h0040);
        check_output("halted_hold_flag", halted, 1'b1);
        clear_inputs();
        #2;
        rst = 1'b1;
        #1;
        check_output("halt_rst_pc", pc_out, 16'h0000);
        check_output("halt_rst_flag", halted, 1'b0);
        rst = 1'b0;

        jump_to(16'hFFFE);
        check_output("wrap_seq", pc_seq, 16'h0000);
        step();
        check_output("wrap_pc", pc_out, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
